// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports and the single-port data
// memory lines of the data-memory arbiter.
//   slave  modport : arbiter view (requests and memory read data in; acks,
//                    stall/busy and memory strobes out)
//   master modport : environment view (requesters plus data memory)
// Signals:
//   req_i, we_i        per-port request / write enable (bit p = port p)
//   addr0_i, addr1_i   per-port word address
//   wdata0_i, wdata1_i per-port write data
//   ack_o, rdata_o     one-cycle completion pulse and read data
//   stall_o, busy_o    CPU stall and arbiter-busy indications
//   mem_*              address, write data, MemRead, MemWrite, read data
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [1:0]        req_i;
  logic [1:0]        we_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata0_i;
  logic [DATA_W-1:0] wdata1_i;
  logic [1:0]        ack_o;
  logic [DATA_W-1:0] rdata_o;
  logic              stall_o;
  logic              busy_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    output ack_o, rdata_o, stall_o, busy_o,
    output mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );

  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    input  ack_o, rdata_o, stall_o, busy_o,
    input  mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port data
// memory. Port 0 is the CPU MEM stage, port 1 the debug/program loader.
// One access takes three cycles: IDLE (grant + latch) -> ISSUE (memory
// strobes for exactly one cycle, read data captured) -> DONE (ack pulse).
// Ports:
//   clk    clock, all state changes on posedge
//   reset  synchronous active-high reset
//   bus    dmem_arbiter_if.slave (requests, acks, stall/busy, memory lines)
// Optional build macro DMEM_ARB_RR_EN: round-robin arbitration on contention
// using a last_grant register (reset 1). Undefined: port 0 always wins.
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              owner_r;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              grant_s;
  logic              take_s;
  logic [1:0]        ack_s;
  logic [DATA_W-1:0] rdata_s;
  logic              mem_read_s;
  logic              mem_write_s;

`ifdef DMEM_ARB_RR_EN
  logic              last_grant_r;
`endif

  // A grant happens only in IDLE with at least one port requesting.
  assign take_s = (state_r == IDLE) && (bus.req_i != 2'b00);

  // Winner selection; only meaningful while take_s is high.
  always_comb begin
    grant_s = 1'b0;
`ifdef DMEM_ARB_RR_EN
    if (bus.req_i == 2'b11) begin
      grant_s = ~last_grant_r;
    end else if (bus.req_i[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
`else
    if (bus.req_i[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: fixed three-cycle sequence once a request is seen.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_i != 2'b00) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Latch the winner and its address/direction/data in the granting cycle;
  // later changes on the request lines are ignored until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      we_r    <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
    end else if (take_s) begin
      owner_r <= grant_s;
      addr_r  <= grant_s ? bus.addr1_i  : bus.addr0_i;
      we_r    <= grant_s ? bus.we_i[1]  : bus.we_i[0];
      wdata_r <= grant_s ? bus.wdata1_i : bus.wdata0_i;
    end
  end

  // Capture combinational memory read data at the edge closing ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if ((state_r == ISSUE) && !we_r) begin
      rdata_r <= bus.mem_rdata_i;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember the most recent winner so contention alternates.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (take_s) begin
      last_grant_r <= grant_s;
    end
  end
`endif

  // Output decode. The write strobe is gated by reset so a reset landing in
  // ISSUE never commits a write; an ack in DONE is still driven under reset.
  always_comb begin
    ack_s       = 2'b00;
    rdata_s     = {DATA_W{1'b0}};
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    case (state_r)
      IDLE: begin
        ack_s = 2'b00;
      end
      ISSUE: begin
        mem_read_s  = ~we_r;
        mem_write_s = we_r & ~reset;
      end
      DONE: begin
        ack_s[owner_r] = 1'b1;
        if (we_r) begin
          rdata_s = {DATA_W{1'b0}};
        end else begin
          rdata_s = rdata_r;
        end
      end
      default: begin
        ack_s = 2'b00;
      end
    endcase
  end

  assign bus.ack_o       = ack_s;
  assign bus.rdata_o     = rdata_s;
  assign bus.mem_read_o  = mem_read_s;
  assign bus.mem_write_o = mem_write_s;
  assign bus.mem_addr_o  = addr_r;
  assign bus.mem_wdata_o = wdata_r;
  assign bus.busy_o      = (state_r != IDLE);
  assign bus.stall_o     = bus.req_i[0] & ~ack_s[0];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// two-port traffic with random resets, checked by a transaction-level model
// and a scoreboard queue popped by an independent monitor.
module tb_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign bus.req_i    = {req1, req0};
  assign bus.we_i     = {we1, we0};
  assign bus.addr0_i  = a0;
  assign bus.addr1_i  = a1;
  assign bus.wdata0_i = d0;
  assign bus.wdata1_i = d1;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Power-up contents of every memory word, shared by the memory and model.
  function automatic logic [DW-1:0] init_val(input int a);
    logic [DW-1:0] v;
    v = 32'h9E3779B9 * 32'(a + 1);
    return v ^ 32'h0F0F0F0F;
  endfunction

  // Behavioural single-port data memory with combinational read.
  logic [DW-1:0] mem [0:31];
  logic [31:0]   mem_wr = 32'd0;
  assign bus.mem_rdata_i = mem_wr[bus.mem_addr_o] ? mem[bus.mem_addr_o]
                                                  : init_val(int'(bus.mem_addr_o));
  always @(posedge clk) begin
    if (bus.mem_write_o) begin
      mem[bus.mem_addr_o]    <= bus.mem_wdata_o;
      mem_wr[bus.mem_addr_o] <= 1'b1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: the arbiter is free from edge free_edge on; a grant at
  // edge g issues in the following cycle, acks one edge later, and the next
  // grant is possible three edges after g. Reset cancels anything not yet acked.
  typedef struct {
    int            port;
    logic [DW-1:0] rdata;
    int            ack_edge;
  } exp_t;

  exp_t          exp_q[$];
  int            ack_log[$];
  logic [DW-1:0] ref_mem [0:31];
  logic [31:0]   ref_wr = 32'd0;
  int            e = 0, free_edge = 0, cur_g = 0, cur_owner = 0;
  bit            cur_valid = 1'b0, cur_we = 1'b0, last = 1'b1, mon_en = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(int'(a));
  endfunction

  always @(posedge clk) begin : model
    int   w;
    exp_t x;
    e = e + 1;
    if (reset) begin
      if (cur_valid && e == cur_g + 1 && exp_q.size() > 0) void'(exp_q.pop_back());
      cur_valid = 1'b0;
      free_edge = e + 1;
      last      = 1'b1;
    end else begin
      if (cur_valid && e == cur_g + 1 && cur_we) begin
        ref_mem[cur_addr] = cur_wdata;
        ref_wr[cur_addr]  = 1'b1;
      end
      if (cur_valid && e >= cur_g + 2) cur_valid = 1'b0;
      if (e >= free_edge && (req0 || req1)) begin
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
          w = last ? 0 : 1;
`else
          w = 0;
`endif
        end else begin
          w = req0 ? 0 : 1;
        end
        last       = w[0];
        cur_valid  = 1'b1;
        cur_g      = e;
        cur_owner  = w;
        cur_we     = (w == 1) ? we1 : we0;
        cur_addr   = (w == 1) ? a1 : a0;
        cur_wdata  = (w == 1) ? d1 : d0;
        x.port     = w;
        x.rdata    = cur_we ? 32'd0 : ref_rd(cur_addr);
        x.ack_edge = e + 1;
        exp_q.push_back(x);
        free_edge  = e + 3;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    bit   in_issue, in_done;
    exp_t x;
    if (mon_en) begin
      in_issue = cur_valid && (e == cur_g);
      in_done  = cur_valid && (e == cur_g + 1);
      chk("busy", bus.busy_o, in_issue || in_done);
      chk("mem_read", bus.mem_read_o, in_issue && !cur_we);
      chk("mem_write", bus.mem_write_o, in_issue && cur_we && !reset);
      if (in_issue) begin
        chk("mem_addr", bus.mem_addr_o, cur_addr);
        chk("mem_wdata", bus.mem_wdata_o, cur_wdata);
      end
      chk("stall", bus.stall_o, req0 && !(in_done && cur_owner == 0));
      if (bus.ack_o != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", bus.ack_o, 2'b00);
        end else begin
          x = exp_q.pop_front();
          ack_log.push_back(x.port);
          chk("ack_port", bus.ack_o, (x.port == 1) ? 2'b10 : 2'b01);
          chk("ack_rdata", bus.rdata_o, x.rdata);
          chk("ack_cycle", e, x.ack_edge);
        end
      end else begin
        chk("rdata_idle", bus.rdata_o, 32'd0);
        if (exp_q.size() > 0 && exp_q[0].ack_edge <= e) begin
          x = exp_q.pop_front();
          chk("missing_ack", 2'b00, (x.port == 1) ? 2'b10 : 2'b01);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0 = 1'b1; we0 = w; a0 = a; d0 = d;
    end else begin
      req1 = 1'b1; we1 = w; a1 = a; d1 = d;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  // Raise a request, wait (bounded) for its ack, return at posedge+1 with the
  // request still held so the caller can chain or drop it.
  task automatic do_req(input int p, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int limit, output logic [DW-1:0] rd);
    bit got;
    got = 1'b0;
    rd  = '0;
    set_req(p, w, a, d);
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (bus.ack_o[p]) begin
        got = 1'b1;
        rd  = bus.rdata_o;
      end
    end
    chk("ack_seen", got, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_requester(input int p, input int n);
    logic [DW-1:0] rd;
    for (int k = 0; k < n; k++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        drop(p);
        repeat (gap) @(posedge clk);
        #1;
      end
      do_req(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 2000, rd);
    end
    drop(p);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DW-1:0] rd, ra, rb, prior;
    bit            done0, done1;
    int            exp_log[5];
    done0 = 1'b0;
    done1 = 1'b0;

    // Reset state, with port 0 requesting to observe stall following req.
    req0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ack", bus.ack_o, 2'b00);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_mem_read", bus.mem_read_o, 1'b0);
    chk("rst_mem_write", bus.mem_write_o, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_o, 5'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_stall", bus.stall_o, 1'b1);
    @(posedge clk);
    #1;
    req0  = 1'b0;
    reset = 1'b0;

    // Port 0 write then back-to-back read of the same word.
    do_req(0, 1'b1, 5'd3, 32'hDEADBEEF, 10, rd);
    do_req(0, 1'b0, 5'd3, 32'd0, 10, rd);
    drop(0);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);

    // Contention: port 0 read addr 1 against port 1 write addr 2.
    fork
      begin do_req(0, 1'b0, 5'd1, 32'd0, 20, ra); drop(0); end
      begin do_req(1, 1'b1, 5'd2, 32'h55, 20, rb); drop(1); end
    join
    chk("rd_addr1", ra, init_val(1));
    do_req(0, 1'b0, 5'd2, 32'd0, 10, rd);
    drop(0);
    chk("rd_55", rd, 32'h00000055);

    // Reset during ISSUE of a port 1 write: nothing commits, no ack.
    prior = init_val(7);
    @(posedge clk);
    #1;
    set_req(1, 1'b1, 5'd7, 32'h1234);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drop(1);
    @(negedge clk);
    chk("rstiss_busy", bus.busy_o, 1'b1);
    chk("rstiss_mem_write", bus.mem_write_o, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstiss_ack", bus.ack_o, 2'b00);
    chk("rstiss_busy_after", bus.busy_o, 1'b0);
    @(posedge clk);
    #1;
    do_req(0, 1'b0, 5'd7, 32'd0, 10, rd);
    drop(0);
    chk("rd_addr7_prior", rd, prior);

    // Ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", bus.busy_o, 1'b0);
      chk("idle_rw", {bus.mem_read_o, bus.mem_write_o}, 2'b00);
      chk("idle_ack", bus.ack_o, 2'b00);
    end

    // Port 1 held while port 0 issues four back-to-back reads, after reset.
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ack_log.delete();
    fork
      begin do_req(1, 1'b0, 5'd9, 32'd0, 100, rb); drop(1); end
      begin
        for (int i = 0; i < 4; i++) do_req(0, 1'b0, 5'(i + 10), 32'd0, 100, ra);
        drop(0);
      end
    join
`ifdef DMEM_ARB_RR_EN
    exp_log = '{0, 1, 0, 0, 0};
`else
    exp_log = '{0, 0, 0, 0, 1};
`endif
    chk("starve_count", ack_log.size(), 5);
    for (int i = 0; i < 5 && i < ack_log.size(); i++) chk("starve_order", ack_log[i], exp_log[i]);

    // Randomized two-port traffic with occasional resets.
    fork
      begin rand_requester(0, 40); done0 = 1'b1; end
      begin rand_requester(1, 40); done1 = 1'b1; end
      begin
        for (int c = 0; c < 20000 && !(done0 && done1); c++) begin
          @(posedge clk);
          #1;
          reset = ($urandom_range(0, 39) == 0);
        end
        reset = 1'b0;
      end
    join

    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
